// File: rtl/load_ctrl_pkg.sv
// load_ctrl_pkg
// Shared definitions for the load controller: the operating-mode encoding,
// default address-map constants and the entry-to-byte-address helper.
package load_ctrl_pkg;

  // Encoding is visible to software/LEDs, so it is fixed explicitly.
  typedef enum logic [1:0] {
    MODE_LOAD   = 2'd0,
    MODE_REVIEW = 2'd1,
    MODE_RUN    = 2'd2,
    MODE_HALTED = 2'd3
  } mode_e;

  localparam int unsigned ADDR_STEP_DEFAULT = 4;
  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h0000_0000;

  // Byte address of entry idx.
  function automatic logic [31:0] entry_addr(input logic [31:0] base,
                                             input int unsigned step,
                                             input logic [31:0] idx);
    return base + 32'(step) * idx;
  endfunction

endpackage

// File: rtl/load_controller_if.sv
// load_controller_if
// External load port between the load controller and the CPU.
//   addr      : load/browse byte address
//   wr_en     : one-cycle memory write strobe
//   wr_data   : data word to be written
//   cpu_start : run enable to the CPU
//   halt      : CPU halt indication (driven by the CPU side)
// master = load controller, slave = CPU.
interface load_controller_if;
  logic [31:0] addr;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        cpu_start;
  logic        halt;

  modport master (output addr, wr_en, wr_data, cpu_start, input halt);
  modport slave  (input addr, wr_en, wr_data, cpu_start, output halt);
endinterface

// File: rtl/load_controller_rise_edge.sv
// rise_edge
// 1-bit level-to-pulse detector. pulse_o is high in the cycle where level_i
// is high and was low in the previous cycle. clr_i synchronously clears the
// history so a level held high across a clear produces a fresh edge.
//   clk_i   : clock
//   clr_i   : synchronous clear of the history register
//   level_i : debounced input level
//   pulse_o : rising-edge indication (combinational from level_i)
module rise_edge (
  input  logic clk_i,
  input  logic clr_i,
  input  logic level_i,
  output logic pulse_o
);

  logic prev_q;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= level_i;
    end
  end

  assign pulse_o = level_i & ~prev_q;

endmodule

// File: rtl/load_controller.sv
// load_controller
// Sequences operator program/data entry into the CPU memory and gates CPU
// execution through the LOAD / REVIEW / RUN / HALTED mode machine.
// Ports:
//   clk_i, rst_i      : clock, synchronous active-high reset
//   next_i/pre_i      : browse buttons (rising edges act)
//   verify_i          : write button (rising edge writes in LOAD)
//   stop_i            : 0 = operator input, 1 = input locked
//   start_i           : run request
//   number_i          : 12-bit operator value
//   count_o           : current entry index
//   mode_o            : current mode
//   loaded_o          : highest written index + 1
//   bus (master)      : addr / wr_en / wr_data / cpu_start out, halt in
// Build option: define LOAD_CTRL_AUTOINC_EN to make a Verify write in LOAD
// also advance the index; the address still shows the written entry during
// the strobe and moves on the following edge.
// DEPTH must be at least 2.
module load_controller
  import load_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned ADDR_STEP = ADDR_STEP_DEFAULT,
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT,
  localparam int unsigned CW       = $clog2(DEPTH),
  localparam int unsigned LW       = CW + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            next_i,
  input  logic            pre_i,
  input  logic            verify_i,
  input  logic            stop_i,
  input  logic            start_i,
  input  logic [11:0]     number_i,
  output logic [CW-1:0]   count_o,
  output mode_e           mode_o,
  output logic [LW-1:0]   loaded_o,
  load_controller_if.master bus
);

  // Button edge detection: bit 0 Next, bit 1 Pre, bit 2 Verify.
  logic [2:0] btn_level;
  logic [2:0] btn_edge;

  assign btn_level = {verify_i, pre_i, next_i};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_edge
      rise_edge u_edge (
        .clk_i   (clk_i),
        .clr_i   (rst_i),
        .level_i (btn_level[gi]),
        .pulse_o (btn_edge[gi])
      );
    end
  endgenerate

  logic next_e, pre_e, verify_e;
  assign next_e   = btn_edge[0];
  assign pre_e    = btn_edge[1];
  assign verify_e = btn_edge[2];

  // State
  mode_e         mode_q, mode_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   addr_q, addr_d;
  logic          wr_en_q, wr_en_d;
  logic [31:0]   wr_data_q, wr_data_d;
  logic          cpu_start_q, cpu_start_d;
  logic [LW-1:0] loaded_q, loaded_d;

  // Mode machine (next state)
  always_comb begin
    mode_d = mode_q;
    case (mode_q)
      MODE_LOAD:   if (stop_i) mode_d = MODE_REVIEW;
      // Stop=0 wins over Start so a RUN exit via Stop=0 lands in LOAD next.
      MODE_REVIEW: begin
        if (!stop_i)      mode_d = MODE_LOAD;
        else if (start_i) mode_d = MODE_RUN;
      end
      MODE_RUN: begin
        if (!start_i || !stop_i) mode_d = MODE_REVIEW;
        else if (bus.halt)       mode_d = MODE_HALTED;
      end
      MODE_HALTED: if (!start_i) mode_d = MODE_REVIEW;
      default:     mode_d = MODE_LOAD;
    endcase
  end

  // Index / write datapath. Buttons are evaluated in the current (old) mode.
  logic          browse, do_write;
  logic [CW-1:0] count_inc, count_dec, addr_idx;
  logic [LW-1:0] written_len;

  assign browse      = (mode_q == MODE_LOAD) || (mode_q == MODE_REVIEW);
  assign do_write    = (mode_q == MODE_LOAD) && verify_e;
  assign count_inc   = (count_q == CW'(DEPTH - 1)) ? '0 : count_q + CW'(1);
  assign count_dec   = (count_q == '0) ? CW'(DEPTH - 1) : count_q - CW'(1);
  assign written_len = {1'b0, count_q} + LW'(1);

  always_comb begin
    count_d   = count_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    loaded_d  = loaded_q;
    if (do_write) begin
      // A write swallows any simultaneous Next/Pre.
      wr_en_d   = 1'b1;
      wr_data_d = {20'h00000, number_i};
      if (written_len > loaded_q) loaded_d = written_len;
`ifdef LOAD_CTRL_AUTOINC_EN
      count_d   = count_inc;
`endif
    end else if (browse && next_e && !pre_e) begin
      count_d = count_inc;
    end else if (browse && pre_e && !next_e) begin
      count_d = count_dec;
    end
    // During a strobe the address must show the entry being written.
    addr_idx    = do_write ? count_q : count_d;
    addr_d      = entry_addr(BASE_ADDR, ADDR_STEP, 32'(addr_idx));
    cpu_start_d = (mode_d == MODE_RUN);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q      <= MODE_LOAD;
      count_q     <= '0;
      addr_q      <= BASE_ADDR;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      cpu_start_q <= 1'b0;
      loaded_q    <= '0;
    end else begin
      mode_q      <= mode_d;
      count_q     <= count_d;
      addr_q      <= addr_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
      cpu_start_q <= cpu_start_d;
      loaded_q    <= loaded_d;
    end
  end

  assign count_o       = count_q;
  assign mode_o        = mode_q;
  assign loaded_o      = loaded_q;
  assign bus.addr      = addr_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.cpu_start = cpu_start_q;

endmodule

// File: tb/tb_load_controller.sv
// tb_load_controller
// Table-driven entry sequences followed by hand-written mode and reset
// sequences. Expected writes go into a scoreboard queue when Verify is
// driven and are popped when the strobe appears on the load port.
module tb_load_controller;
  import load_ctrl_pkg::*;

  localparam int DEPTH = 16;
  localparam int STEP  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        next, pre, verify, stop, start;
  logic [11:0] number;
  logic [3:0]  count;
  mode_e       mode;
  logic [4:0]  loaded;

  load_controller_if bus ();

  load_controller dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .next_i   (next),
    .pre_i    (pre),
    .verify_i (verify),
    .stop_i   (stop),
    .start_i  (start),
    .number_i (number),
    .count_o  (count),
    .mode_o   (mode),
    .loaded_o (loaded),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard of expected write strobes.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t sb[$];

  task automatic expect_write(input int idx, input logic [11:0] num);
    wr_t w;
    w.addr = 32'(idx * STEP);
    w.data = {20'h00000, num};
    sb.push_back(w);
  endtask

  always @(negedge clk) begin : monitor
    wr_t e;
    if (bus.wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_wren: got strobe addr=0x%0h, expected none", bus.addr);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", bus.addr, e.addr);
        chk("wr_data", bus.wr_data, e.data);
        $display("write addr=0x%0h data=0x%0h", bus.addr, bus.wr_data);
      end
    end
  end

  // Stimulus table, expectations produced by a small index model.
  typedef struct {
    bit          n, p, v;
    logic [11:0] num;
    logic [3:0]  exp_count;
    logic [31:0] exp_addr;
    logic [4:0]  exp_loaded;
  } vec_t;
  vec_t tbl[$];
  int m_count = 0;
  int m_loaded = 0;

  task automatic add(input bit n, input bit p, input bit v, input logic [11:0] num);
    vec_t t;
    int   wr_idx;
    t.n = n; t.p = p; t.v = v; t.num = num;
    wr_idx = m_count;
    if (v) begin
      if (m_count + 1 > m_loaded) m_loaded = m_count + 1;
`ifdef LOAD_CTRL_AUTOINC_EN
      m_count = (m_count + 1) % DEPTH;
`endif
    end else if (n && !p) begin
      m_count = (m_count + 1) % DEPTH;
    end else if (p && !n) begin
      m_count = (m_count + DEPTH - 1) % DEPTH;
    end
    t.exp_count  = 4'(m_count);
    t.exp_addr   = 32'((v ? wr_idx : m_count) * STEP);
    t.exp_loaded = 5'(m_loaded);
    tbl.push_back(t);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_mode"},      32'(mode), 32'(MODE_LOAD));
    chk({tag, "_count"},     32'(count), 32'd0);
    chk({tag, "_addr"},      bus.addr, 32'h0);
    chk({tag, "_wren"},      32'(bus.wr_en), 32'd0);
    chk({tag, "_wrdata"},    bus.wr_data, 32'h0);
    chk({tag, "_cpustart"},  32'(bus.cpu_start), 32'd0);
    chk({tag, "_loaded"},    32'(loaded), 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; next = 0; pre = 0; verify = 0; stop = 0; start = 0;
    number = 12'h000; bus.halt = 1'b0;

    // Build the table.
    for (int i = 0; i < 17; i++) add(1, 0, 0, 12'h000);  // 1..15, 0, 1
    add(0, 1, 0, 12'h000);                              // 0
    add(0, 1, 0, 12'h000);                              // wrap to 15
    while (m_count != 5) add(1, 0, 0, 12'h000);
    add(0, 0, 1, 12'hABC);                              // write entry 5
    add(1, 1, 0, 12'h000);                              // Next+Pre: no move
    while (m_count != 2) add(0, 1, 0, 12'h000);
    add(1, 0, 1, 12'h123);                              // Verify+Next at 2
    while (m_count != 15) add(0, 1, 0, 12'h000);
    add(0, 0, 1, 12'hFFF);                              // last entry: Loaded=16

    tick();
    tick();
    check_reset("reset");
    rst = 1'b0;
    tick();

    for (int i = 0; i < tbl.size(); i++) begin
      next = tbl[i].n; pre = tbl[i].p; verify = tbl[i].v; number = tbl[i].num;
      if (tbl[i].v) expect_write(int'(tbl[i].exp_addr) / STEP, tbl[i].num);
      tick();
      chk("vec_count",  32'(count),  32'(tbl[i].exp_count));
      chk("vec_addr",   bus.addr,    tbl[i].exp_addr);
      chk("vec_loaded", 32'(loaded), 32'(tbl[i].exp_loaded));
      next = 0; pre = 0; verify = 0;
      tick();
      chk("vec_addr_settled", bus.addr, 32'(tbl[i].exp_count) * STEP);
      $display("vec %0d n=%0b p=%0b v=%0b count=%0d addr=0x%0h loaded=%0d",
               i, tbl[i].n, tbl[i].p, tbl[i].v, count, bus.addr, loaded);
    end

    // Held Next: one step only.
    next = 1; tick(); tick(); tick(); next = 0; tick();
    m_count = (m_count + 1) % DEPTH;
    chk("held_next_count", 32'(count), 32'(m_count));
    $display("held next count=%0d", count);

    // Held Verify: exactly one strobe.
    number = 12'h055;
    expect_write(m_count, 12'h055);
    verify = 1; tick(); tick(); tick(); verify = 0; tick();
`ifdef LOAD_CTRL_AUTOINC_EN
    m_count = (m_count + 1) % DEPTH;
`endif
    chk("held_verify_count", 32'(count), 32'(m_count));
    chk("held_verify_data", bus.wr_data, 32'h0000_0055);
    $display("held verify count=%0d data=0x%0h", count, bus.wr_data);

    // LOAD -> REVIEW -> RUN -> HALTED -> REVIEW -> LOAD
    stop = 1; tick();
    chk("review_mode", 32'(mode), 32'(MODE_REVIEW));
    chk("review_cpustart", 32'(bus.cpu_start), 32'd0);
    start = 1; tick();
    chk("run_mode", 32'(mode), 32'(MODE_RUN));
    chk("run_cpustart", 32'(bus.cpu_start), 32'd1);
    next = 1; verify = 1; tick();
    chk("run_next_ignored", 32'(count), 32'(m_count));
    next = 0; verify = 0; tick();
    bus.halt = 1'b1; tick();
    chk("halted_mode", 32'(mode), 32'(MODE_HALTED));
    chk("halted_cpustart", 32'(bus.cpu_start), 32'd0);
    bus.halt = 1'b0; tick();
    chk("halted_hold", 32'(mode), 32'(MODE_HALTED));
    start = 0; tick();
    chk("halted_to_review", 32'(mode), 32'(MODE_REVIEW));
    verify = 1; tick(); verify = 0; tick();
    chk("review_verify_count", 32'(count), 32'(m_count));
    next = 1; tick();
    m_count = (m_count + 1) % DEPTH;
    chk("review_browse", 32'(count), 32'(m_count));
    next = 0; tick();
    stop = 0; tick();
    chk("review_to_load", 32'(mode), 32'(MODE_LOAD));
    start = 1; tick();
    chk("load_start_ignored", 32'(mode), 32'(MODE_LOAD));
    chk("load_start_cpustart", 32'(bus.cpu_start), 32'd0);
    start = 0; tick();
    $display("mode sequence done mode=%0d count=%0d", mode, count);

    // RUN exit via Stop=0: REVIEW first, then LOAD.
    stop = 1; tick(); start = 1; tick();
    chk("run2_mode", 32'(mode), 32'(MODE_RUN));
    stop = 0; tick();
    chk("run_stop0_review", 32'(mode), 32'(MODE_REVIEW));
    tick();
    chk("run_stop0_load", 32'(mode), 32'(MODE_LOAD));
    start = 0; tick();

    // Verify on the same edge as LOAD->REVIEW: write uses the old mode.
    number = 12'h3A5;
    expect_write(m_count, 12'h3A5);
    stop = 1; verify = 1; tick();
    chk("modechg_mode", 32'(mode), 32'(MODE_REVIEW));
    chk("modechg_wren", 32'(bus.wr_en), 32'd1);
    verify = 0; stop = 0; tick();
    chk("modechg_back_load", 32'(mode), 32'(MODE_LOAD));
    $display("mode-change write done");

    // Reset during a write strobe.
    number = 12'h777;
    expect_write(m_count, 12'h777);
    verify = 1; tick();
    chk("strobe_before_reset", 32'(bus.wr_en), 32'd1);
    verify = 0; rst = 1; next = 1; tick();
    check_reset("rst_wr");
    rst = 0; next = 0; tick();

    // Reset during RUN.
    stop = 1; tick(); start = 1; tick();
    chk("run3_cpustart", 32'(bus.cpu_start), 32'd1);
    rst = 1; tick();
    check_reset("rst_run");
    rst = 0; stop = 0; start = 0; tick();
    chk("post_reset_mode", 32'(mode), 32'(MODE_LOAD));

    tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
